rr_hold_arbiter: RTL and testbench
==================================

// Module: rr_hold_arbiter
// PURPOSE
//  Registered round-robin arbiter sharing one downstream resource among NUM_PORTS requesters.
//  A grant is held while the owner keeps requesting, up to MAX_HOLD cycles (burst lock).
//  The owner then drops to lowest priority. Replaces fixed-priority selection where starvation matters.
// PARAMETERS
//  NUM_PORTS  4  number of requesters, >=2
//  MAX_HOLD   8  max consecutive cycles one owner may hold the grant; 0 = unlimited
//  ID_W       $clog2(NUM_PORTS)  width of grant_id_o (derived, not overridden)
//  CNT_W      $clog2(MAX_HOLD+1) width of hold counter (derived; 1 when MAX_HOLD=0)
// PORTS
//  clk_i          in   1          clock; all state on rising edge
//  rst_ni         in   1          asynchronous active-low reset
//  requests_i     in   NUM_PORTS  level request per port
//  done_i         in   1          current owner ends its transfer this cycle
//  grants_o       out  NUM_PORTS  registered one-hot grant, all-zero when idle
//  grant_valid_o  out  1          |grants_o
//  grant_id_o     out  ID_W       index of owner; 0 when idle
//  hold_count_o   out  CNT_W      cycles current grant has been asserted (1 on first cycle)
// BEHAVIOUR
//  Reset (async assert, sync release): grants_o=0, grant_valid_o=0, grant_id_o=0, hold_count_o=0,
//   state=ARB_IDLE, rr pointer ptr=0 (port 0 highest priority). Reset mid-grant drops grant immediately.
//  Pick: winner = first set requests_i bit scanning ptr, ptr+1, ... NUM_PORTS-1, 0, ... ptr-1 (wraps).
//  ARB_IDLE: requests_i==0 -> stay. Else at the edge load grants_o=onehot(winner), grant_id_o=winner,
//   hold_count_o=1, ptr=winner+1 mod NUM_PORTS, go ARB_GRANT. Latency: request at cycle N -> grant at N+1.
//  ARB_GRANT: release when any holds in the current cycle:
//   requests_i[grant_id_o]==0, OR done_i==1, OR (MAX_HOLD!=0 AND hold_count_o==MAX_HOLD).
//   No release: grants_o unchanged; hold_count_o+1 (saturates at 2**CNT_W-1 when MAX_HOLD=0).
//   Release with requests_i excluding a dropped owner nonzero: re-pick at the same edge (no bubble).
//    New grant from ptr (already owner+1), so the old owner is lowest priority and wins again only if
//    it is the sole requester. hold_count_o=1, ptr=winner+1.
//   Release with no eligible requester: grants_o=0, grant_id_o=0, hold_count_o=0, go ARB_IDLE; ptr kept.
//  Simultaneous: done_i and hold expiry in the same cycle = one release. done_i in ARB_IDLE is ignored.
//   New requests arriving during a grant never preempt it.
//  Invariant: grants_o is one-hot or zero; grants_o[grant_id_o]==grant_valid_o; owner never re-granted
//   while another port requests after its release.
//  All outputs driven straight from flops; no combinational path from requests_i to grants_o.
// STRUCTURE
//  Package rr_arb_pkg: typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e.
//   It also holds a localparam function for clog2 that guards NUM_PORTS/MAX_HOLD edge cases.
//  Sub-module rr_pick #(NUM_PORTS): combinational.
//   In: req, ptr. Out: winner one-hot, winner id, any.
//   Implemented as a double-width masked fixed-priority scan.
//  Top: state flop, ptr flop, grant/id/count flops, release logic.
//  Parameter assertions: NUM_PORTS>=2.
// TESTING
//  1 Reset with requests_i=4'b1111 held -> all outputs 0. First edge after release: grants_o=0001,
//    grant_id_o=0, hold_count_o=1.
//  2 requests_i=1111 held, done_i=0, MAX_HOLD=8 -> port0 for 8 cycles.
//    Then 1,2,3 each 8 cycles back-to-back, no idle cycle.
//  3 Owner port2 drops request at hold_count_o=3 while requests_i=1011 -> next edge grants_o=1000
//    (port3), hold_count_o=1.
//  4 Sole requester port1 hits MAX_HOLD -> re-granted port1 at same edge, hold_count_o=1.
//    grant_valid_o never drops.
//  5 done_i pulse with requests_i=0 -> next edge grants_o=0, ARB_IDLE.
//    Later request 0100 -> grant after 1 cycle.
//  6 rst_ni asserted mid-grant (hold_count_o=5) -> outputs 0 asynchronously, before next clk_i edge.
//    After release, ptr=0 ordering restarts.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared state encoding and width helper for the hold arbiter
package rr_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner select as a double-width masked fixed-priority scan
module rr_pick import rr_arb_pkg::*; #(
  parameter int NUM_PORTS = 4,
  localparam int ID_W = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [NUM_PORTS-1:0] win_oh,
  output logic [ID_W-1:0]      win_id,
  output logic                 any
);
  logic [2*NUM_PORTS-1:0] dbl;
  assign dbl = {req, req} & ({2*NUM_PORTS{1'b1}} << ptr);
  always_comb begin
    win_id = '0;
    for (int i = 2*NUM_PORTS-1; i >= 0; i--)
      if (dbl[i]) win_id = ID_W'(i % NUM_PORTS);
  end
  assign any = |req;
  assign win_oh = any ? NUM_PORTS'(1) << win_id : '0;
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered round-robin arbiter with burst-lock hold limit
module rr_hold_arbiter import rr_arb_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W = clog2(NUM_PORTS),
  localparam int CNT_W = clog2(MAX_HOLD + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_PORTS-1:0] requests_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] grants_o,
  output logic                 grant_valid_o,
  output logic [ID_W-1:0]      grant_id_o,
  output logic [CNT_W-1:0]     hold_count_o
);
  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("rr_hold_arbiter: NUM_PORTS must be >= 2");
  end
  arb_state_e state;
  logic [ID_W-1:0] ptr, win_id, nxt;
  logic [NUM_PORTS-1:0] win_oh;
  logic any, rel;
  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .req(requests_i), .ptr(ptr), .win_oh(win_oh), .win_id(win_id), .any(any)
  );
  assign nxt = (win_id == ID_W'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;
  // ptr already points past the owner, so a re-pick naturally demotes it
  assign rel = !requests_i[grant_id_o] || done_i ||
               (MAX_HOLD != 0 && hold_count_o == CNT_W'(MAX_HOLD));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
      ptr <= '0;
      grants_o <= '0;
      grant_valid_o <= 1'b0;
      grant_id_o <= '0;
      hold_count_o <= '0;
    end else if (state == ARB_IDLE || rel) begin
      state <= any ? ARB_GRANT : ARB_IDLE;
      ptr <= any ? nxt : ptr;
      grants_o <= win_oh;
      grant_valid_o <= any;
      grant_id_o <= any ? win_id : '0;
      hold_count_o <= any ? CNT_W'(1) : '0;
    end else begin
      hold_count_o <= (hold_count_o == '1) ? hold_count_o : hold_count_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed and random checks against an owner/pointer reference model
module tb_rr_hold_arbiter;
  localparam int N = 4;
  localparam int MH = 8;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] requests_i = '0;
  logic done_i = 1'b0;
  logic [N-1:0] grants_o;
  logic grant_valid_o;
  logic [1:0] grant_id_o;
  logic [3:0] hold_count_o;
  int tests = 0;
  int fails = 0;
  int m_owner = -1;
  int m_hold = 0;
  int m_ptr = 0;
  always #5 clk_i = ~clk_i;
  rr_hold_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .requests_i(requests_i), .done_i(done_i),
    .grants_o(grants_o), .grant_valid_o(grant_valid_o), .grant_id_o(grant_id_o),
    .hold_count_o(hold_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : N'(1) << m_owner;
    chk({tag, ".grants"}, 32'(grants_o), 32'(eg));
    chk({tag, ".valid"}, 32'(grant_valid_o), 32'(m_owner >= 0));
    chk({tag, ".id"}, 32'(grant_id_o), (m_owner < 0) ? 0 : m_owner);
    chk({tag, ".hold"}, 32'(hold_count_o), m_hold);
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_hold = 0;
    m_ptr = 0;
  endtask
  task automatic model_edge();
    bit rel;
    int w;
    rel = (m_owner < 0) || !requests_i[m_owner] || done_i || (MH != 0 && m_hold == MH);
    if (rel) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && requests_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_owner = w;
        m_hold = 1;
        m_ptr = (w + 1) % N;
      end else begin
        m_owner = -1;
        m_hold = 0;
      end
    end else m_hold = (m_hold < 15) ? m_hold + 1 : 15;
  endtask
  task automatic step(input logic [N-1:0] req, input logic done, input string tag);
    requests_i = req;
    done_i = done;
    @(posedge clk_i);
    model_edge();
    #1 chk_model(tag);
  endtask
  initial begin
    requests_i = 4'b1111;
    #2 chk_model("t1_in_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'b1111, 1'b0, "t1_first");
    chk("t1_grant0", 32'(grants_o), 32'h1);
    for (int i = 0; i < 31; i++) step(4'b1111, 1'b0, "t2_burst");
    chk("t2_last_owner3", 32'(grant_id_o), 3);
    chk("t2_last_hold8", 32'(hold_count_o), 8);
    model_reset();
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    step(4'b0100, 1'b0, "t3_setup");
    step(4'b0100, 1'b0, "t3_setup");
    step(4'b0100, 1'b0, "t3_setup");
    chk("t3_hold3", 32'(hold_count_o), 3);
    step(4'b1011, 1'b0, "t3_drop");
    chk("t3_port3", 32'(grants_o), 32'h8);
    chk("t3_hold1", 32'(hold_count_o), 1);
    for (int i = 0; i < 8; i++) step(4'b0010, 1'b0, "t4_sole");
    chk("t4_hold8", 32'(hold_count_o), 8);
    step(4'b0010, 1'b0, "t4_regrant");
    chk("t4_port1", 32'(grants_o), 32'h2);
    chk("t4_hold1", 32'(hold_count_o), 1);
    chk("t4_valid", 32'(grant_valid_o), 1);
    step(4'b0000, 1'b1, "t5_done");
    chk("t5_idle", 32'(grant_valid_o), 0);
    step(4'b0000, 1'b1, "t5_done_idle");
    step(4'b0100, 1'b0, "t5_req");
    chk("t5_port2", 32'(grants_o), 32'h4);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, "t6_setup");
    chk("t6_hold5", 32'(hold_count_o), 5);
    rst_ni = 1'b0;
    model_reset();
    #1 chk_model("t6_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(4'b1111, 1'b0, "t6_restart");
    chk("t6_port0", 32'(grants_o), 32'h1);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0) ? 4'(0) : 4'($urandom), ($urandom_range(0, 7) == 0), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
